// File: rtl/toom8_pkg.sv
// Shared constants, state encoding and point-table helpers for the TOOM-8 evaluation stage.
package toom8_pkg;

    localparam int unsigned CHUNK_W    = 129;
    localparam int unsigned NUM_CHUNKS = 8;
    localparam int unsigned NUM_POINTS = 15;
    localparam int unsigned EVAL_W     = 150;

    localparam logic [3:0] LAST_IDX = 4'(NUM_POINTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_EMIT = 2'd2
    } state_e;

    // Finite evaluation point for an index; the point at infinity (14) maps to 0.
    function automatic logic signed [3:0] point_val(input logic [3:0] idx);
        case (idx)
            4'd1:    return  4'sd1;
            4'd2:    return -4'sd1;
            4'd3:    return  4'sd2;
            4'd4:    return -4'sd2;
            4'd5:    return  4'sd3;
            4'd6:    return -4'sd3;
            4'd7:    return  4'sd4;
            4'd8:    return -4'sd4;
            4'd9:    return  4'sd5;
            4'd10:   return -4'sd5;
            4'd11:   return  4'sd6;
            4'd12:   return -4'sd6;
            4'd13:   return  4'sd7;
            default: return  4'sd0;
        endcase
    endfunction

    function automatic logic IS_TRIVIAL(input logic [3:0] idx);
        return (idx == 4'd0) || (idx == LAST_IDX);
    endfunction

endpackage

// File: rtl/toom8_eval_if.sv
// Limb-set input stream and evaluated-point output stream of the evaluation stage.
interface toom8_eval_if;
    import toom8_pkg::*;

    logic                              in_valid;
    logic                              in_ready;
    logic [NUM_CHUNKS*CHUNK_W-1:0]     in_a;
    logic [NUM_CHUNKS*CHUNK_W-1:0]     in_b;
    logic                              out_valid;
    logic                              out_ready;
    logic [3:0]                        out_idx;
    logic signed [EVAL_W-1:0]          out_a;
    logic signed [EVAL_W-1:0]          out_b;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_idx, out_a, out_b
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_idx, out_a, out_b
    );

endinterface

// File: rtl/toom8_horner_step.sv
// One Horner step y = acc*k + c for signed k in [-7,7], built from shifts and adds.
module toom8_horner_step
    import toom8_pkg::*;
(
    input  logic signed [EVAL_W-1:0]  acc,
    input  logic signed [3:0]         k,
    input  logic [CHUNK_W-1:0]        c,
    output logic signed [EVAL_W-1:0]  y
);

    logic [3:0]               neg_k;
    logic [2:0]               mag;
    logic signed [EVAL_W-1:0] prod;

    assign neg_k = 4'(-k);
    assign mag   = k[3] ? neg_k[2:0] : k[2:0];

    // Multiply by |k| as a sum of acc, 2*acc, 4*acc, then restore the sign.
    always_comb begin
        prod = '0;
        if (mag[0]) prod = prod + acc;
        if (mag[1]) prod = prod + (acc <<< 1);
        if (mag[2]) prod = prod + (acc <<< 2);
        if (k[3])   prod = -prod;
        y = prod + $signed({{(EVAL_W-CHUNK_W){1'b0}}, c});
    end

endmodule

// File: rtl/toom8_eval.sv
// Point-serial evaluation of two degree-7 limb polynomials at the 15 TOOM-8 points.
module toom8_eval
    import toom8_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    toom8_eval_if.slave  bus
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] EVAL = ST_EVAL;
    localparam logic [1:0] EMIT = ST_EMIT;

    logic [1:0]               state;
    logic [3:0]               idx;
    logic [2:0]               step;
    logic [CHUNK_W-1:0]       a_r [NUM_CHUNKS];
    logic [CHUNK_W-1:0]       b_r [NUM_CHUNKS];
    logic signed [EVAL_W-1:0] acc_a;
    logic signed [EVAL_W-1:0] acc_b;
    logic signed [EVAL_W-1:0] nxt_a;
    logic signed [EVAL_W-1:0] nxt_b;
    logic signed [3:0]        k;
    logic [2:0]               sel;

    assign k   = point_val(idx);
    assign sel = 3'd7 - step;

    toom8_horner_step u_step_a (
        .acc (acc_a),
        .k   (k),
        .c   (a_r[sel]),
        .y   (nxt_a)
    );

    toom8_horner_step u_step_b (
        .acc (acc_b),
        .k   (k),
        .c   (b_r[sel]),
        .y   (nxt_b)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == EMIT);
    assign bus.out_idx   = idx;
    assign bus.out_a     = acc_a;
    assign bus.out_b     = acc_b;

    // Limbs are only written on the accept edge, so they stay frozen for the whole evaluation.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            for (int unsigned i = 0; i < NUM_CHUNKS; i++) begin
                a_r[i] <= bus.in_a[i*CHUNK_W +: CHUNK_W];
                b_r[i] <= bus.in_b[i*CHUNK_W +: CHUNK_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            step  <= '0;
            acc_a <= '0;
            acc_b <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state <= EVAL;
                        idx   <= '0;
                        step  <= '0;
                    end
                end
                EVAL: begin
                    if (IS_TRIVIAL(idx)) begin
                        acc_a <= {{(EVAL_W-CHUNK_W){1'b0}}, (idx == 4'd0) ? a_r[0] : a_r[7]};
                        acc_b <= {{(EVAL_W-CHUNK_W){1'b0}}, (idx == 4'd0) ? b_r[0] : b_r[7]};
                        state <= EMIT;
                    end else if (step == 3'd0) begin
                        acc_a <= {{(EVAL_W-CHUNK_W){1'b0}}, a_r[7]};
                        acc_b <= {{(EVAL_W-CHUNK_W){1'b0}}, b_r[7]};
                        step  <= 3'd1;
                    end else begin
                        acc_a <= nxt_a;
                        acc_b <= nxt_b;
                        if (step == 3'd7) state <= EMIT;
                        else              step  <= step + 3'd1;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        step <= '0;
                        if (idx == LAST_IDX) begin
                            state <= IDLE;
                            idx   <= '0;
                        end else begin
                            state <= EVAL;
                            idx   <= idx + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
